rng_note_seq: RTL and testbench
===============================

Name: rng_note_seq

Overview:
Parametrised successor of the synthesizer's 16-bit LFSR note source. It contains a configurable-tap XNOR Fibonacci LFSR with runtime seed load and lock-up recovery. It adds a draw FSM that turns a tempo `tick` into one in-range note per request, using rejection sampling, a retry limit with fallback, and a valid/ready output handshake. It sits between the tempo/sequencer logic and the oscillator note decoder.

Parameters:
- LFSR_W, 16: LFSR register width.
- TAPS, 16'hB400: feedback tap mask; bit i set means `lfsr[i]` feeds back (default taps bits 15, 13, 12, 10).
- SEED, 16'hA455: reset seed; also used as the recovery seed.
- NOTE_W, 6: note width.
- NOTE_MAX, 47: highest legal note index (0..NOTE_MAX).
- MAX_TRIES, 4: consecutive rejections that force the fallback note.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous, active-low reset.
- en  in  1  free-run enable; LFSR steps every cycle while high.
- seed_load  in  1  load `seed` into the LFSR this cycle.
- seed  in  LFSR_W  runtime seed value.
- tick  in  1  note request strobe.
- note_ready  in  1  downstream accepts the note.
- note_valid  out  1  `note` is held and valid.
- note  out  NOTE_W  accepted note index.
- rand_out  out  LFSR_W  current LFSR state.
- lockup  out  1  one-cycle pulse when an all-ones seed was replaced.
- tick_drop  out  1  one-cycle pulse when a tick is ignored (FSM not in IDLE).

Behaviour:
- Reset is synchronous and active-low: on a rising `clk` edge with `nrst`=0, all state resets.
  - `lfsr` = SEED, state = IDLE, `note` = 0, `last_note` = 0, try count = 0.
  - `note_valid`, `lockup`, `tick_drop` = 0.
- Reset asserted mid-draw or mid-offer aborts the draw or offer; no note is emitted.
- LFSR:
  - feedback = ~^(lfsr & TAPS).
  - next = {lfsr[LFSR_W-2:0], feedback}.
  - The all-ones state is the XNOR lock state.
- LFSR update priority, highest first:
  1. reset
  2. `seed_load`: if `seed` is all-ones, load SEED and pulse `lockup`; otherwise load `seed`.
  3. step, when `en`=1 or state == DRAW.
  4. hold
- A `seed_load` during DRAW replaces the LFSR value; the draw continues from the new value on the next cycle.
- `rand_out` = `lfsr`, registered, with zero latency from the register.
- FSM states:
  - IDLE:
    - `tick`=1 moves to DRAW and clears the try count.
  - DRAW:
    - Each cycle, candidate = `lfsr[NOTE_W-1:0]`.
    - Accept if candidate <= NOTE_MAX (and passes the repeat check when that feature is enabled).
    - On accept: `note` <= candidate, `last_note` <= candidate, go to OFFER.
    - On reject: try count + 1.
    - On the MAX_TRIES-th consecutive reject: `note` <= fallback = (`last_note` == NOTE_MAX) ? 0 : `last_note` + 1; go to OFFER.
  - OFFER:
    - `note_valid`=1 and `note` stable until `note_ready`=1.
    - On `note_valid` && `note_ready`: go to IDLE.
    - `note_ready` while not OFFER is ignored.
- Latency: tick in cycle 0 gives `note_valid` from cycle 2 at the earliest, and from cycle MAX_TRIES+1 at the latest.
- A `tick` in DRAW or OFFER is ignored and pulses `tick_drop` for one cycle; ticks do not queue.
- A `tick` in the same cycle as an OFFER handshake is also dropped.
- Outputs `note_valid`, `lockup` and `tick_drop` are registered.

Optional Feature:
- Macro: RNG_NO_REPEAT_EN.
- Defined:
  - DRAW also rejects candidate == `last_note`.
  - Fallback is always != `last_note` when NOTE_MAX > 0.
- Undefined:
  - Repeats are accepted.
  - The `last_note` register is still kept for fallback.

Decomposition:
- Package `rng_pkg`:
  - `rng_state_t` enum {IDLE, DRAW, OFFER}.
  - Constants DEFAULT_TAPS = 16'hB400 and DEFAULT_SEED = 16'hA455.
- Sub-module `lfsr_core`:
  - Parameters LFSR_W, TAPS, SEED.
  - Ports `step`, `seed_load`, `seed`, `q`, `lockup`.
  - Contains the shift register, seed mux and lock-up recovery.
- The FSM, try counter and handshake stay in `rng_note_seq`.

Test Plan:
- Reset, `en`=0, `tick` pulse in cycle 0:
  - DRAW sees 0xA455, candidate 21.
  - `note_valid`=1 with `note`=21 at cycle 2.
  - `lfsr` = 0x48AA afterwards.
- Continue, `note_ready`=1, then a second `tick`:
  - `note`=42 (from 0x48AA).
  - `lfsr` = 0x9155.
- `seed_load` with `seed`=0x003F, then `tick`, `en`=0:
  - Candidates 63, 63, 63, 63 (0x003F, 0x007F, 0x00FF, 0x01FF) are all rejected.
  - Fallback `note`=1 (`last_note`=0), `note_valid` after 4 DRAW cycles.
- `seed_load` with `seed`=0xFFFF:
  - `lfsr` = 0xA455.
  - `lockup` high for exactly one cycle.
- Hold `note_ready`=0 in OFFER for 5 cycles and pulse `tick` twice:
  - `note` stable, `note_valid` stays 1.
  - `tick_drop` pulses twice.
  - `note_ready`=1 returns the FSM to IDLE.
- With RNG_NO_REPEAT_EN, `last_note`=21, seed 0xA455:
  - Candidate 21 is rejected.
  - Next candidate 42 (0x48AA) is accepted, `note`=42.

Source files
------------

// File: rtl/rng_note_seq_pkg.sv
// rng_pkg: shared FSM state type and default LFSR constants for rng_note_seq.
package rng_pkg;
    typedef enum logic [1:0] {IDLE, DRAW, OFFER} rng_state_t;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hA455;
endpackage

// File: rtl/rng_note_seq_lfsr_core.sv
// lfsr_core: XNOR Fibonacci LFSR with runtime seed load and all-ones lock-up recovery.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              step,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q,
    output logic              lockup
);
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_lockup;
    logic              w_fb;
    logic              w_seed_ones;

    assign w_fb        = ~^(r_lfsr & TAPS);
    assign w_seed_ones = &seed;
    assign q           = r_lfsr;
    assign lockup      = r_lockup;

    // An all-ones seed would freeze an XNOR LFSR, so it is swapped for SEED.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_lfsr   <= SEED;
            r_lockup <= 1'b0;
        end else begin
            r_lfsr   <= seed_load ? (w_seed_ones ? SEED : seed) :
                        step      ? {r_lfsr[LFSR_W-2:0], w_fb} : r_lfsr;
            r_lockup <= seed_load && w_seed_ones;
        end
    end
endmodule

// File: rtl/rng_note_seq.sv
// rng_note_seq: LFSR note source with rejection-sampling draw FSM and valid/ready output.
// Define RNG_NO_REPEAT_EN to also reject a candidate equal to the previous accepted note.
module rng_note_seq
    import rng_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
    parameter int                NOTE_W    = 6,
    parameter int                NOTE_MAX  = 47,
    parameter int                MAX_TRIES = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              tick,
    input  logic              note_ready,
    output logic              note_valid,
    output logic [NOTE_W-1:0] note,
    output logic [LFSR_W-1:0] rand_out,
    output logic              lockup,
    output logic              tick_drop
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    rng_state_t        r_state, w_next;
    logic [NOTE_W-1:0] r_note, r_last, w_cand, w_fallback;
    logic [TW-1:0]     r_tries;
    logic              r_valid, r_tick_drop;
    logic              w_accept, w_give_up, w_step;

    lfsr_core #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk      (clk),
        .nrst     (nrst),
        .step     (w_step),
        .seed_load(seed_load),
        .seed     (seed),
        .q        (rand_out),
        .lockup   (lockup)
    );

    assign note_valid = r_valid;
    assign note       = r_note;
    assign tick_drop  = r_tick_drop;

    always_ff @(posedge clk) begin
        if (!nrst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE && tick)                       ? DRAW  :
                 (r_state == DRAW && (w_accept || w_give_up))    ? OFFER :
                 (r_state == OFFER && note_ready)                ? IDLE  : r_state;
    end

    always_comb begin
        w_cand     = rand_out[NOTE_W-1:0];
`ifdef RNG_NO_REPEAT_EN
        w_accept   = (w_cand <= NOTE_W'(NOTE_MAX)) && (w_cand != r_last);
`else
        w_accept   = (w_cand <= NOTE_W'(NOTE_MAX));
`endif
        w_give_up  = !w_accept && (r_tries == TW'(MAX_TRIES - 1));
        w_fallback = (r_last == NOTE_W'(NOTE_MAX)) ? '0 : r_last + NOTE_W'(1);
        w_step     = en || (r_state == DRAW);
    end

    // Fallback notes do not update last_note; only accepted draws do.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_note      <= '0;
            r_last      <= '0;
            r_tries     <= '0;
            r_valid     <= 1'b0;
            r_tick_drop <= 1'b0;
        end else begin
            r_tries     <= (r_state == IDLE) ? '0 :
                           (r_state == DRAW && !w_accept) ? r_tries + TW'(1) : r_tries;
            if (r_state == DRAW && w_accept) begin
                r_note <= w_cand;
                r_last <= w_cand;
            end else if (r_state == DRAW && w_give_up) begin
                r_note <= w_fallback;
            end
            r_valid     <= (w_next == OFFER);
            r_tick_drop <= tick && (r_state != IDLE);
        end
    end
endmodule

// File: tb/tb_rng_note_seq.sv
// tb_rng_note_seq: randomized self-checking bench for rng_note_seq against a behavioural draw model.
module tb_rng_note_seq;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] SEED  = 16'hA455;
    localparam int          NMAX  = 47;
    localparam int          TRIES = 4;

    logic        clk = 0, nrst = 0, en = 0, seed_load = 0, tick = 0, note_ready = 0;
    logic [15:0] seed = 0;
    logic        note_valid, lockup, tick_drop;
    logic [5:0]  note;
    logic [15:0] rand_out;

    int          n_checks = 0, n_fail = 0;
    logic [15:0] m_lfsr;
    logic [5:0]  m_last;

    always #5 clk = ~clk;

    rng_note_seq dut (
        .clk(clk), .nrst(nrst), .en(en), .seed_load(seed_load), .seed(seed),
        .tick(tick), .note_ready(note_ready), .note_valid(note_valid), .note(note),
        .rand_out(rand_out), .lockup(lockup), .tick_drop(tick_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = 1'b1;
        for (int i = 0; i < 16; i++) if (TAPS[i]) fb = fb ^ s[i];
        return {s[14:0], fb};
    endfunction

    // Draws candidates from the low bits until one is legal or the retry budget runs out.
    function automatic void draw_model(input logic [15:0] start, input logic [5:0] last,
                                       output logic [5:0] n, output int d,
                                       output logic [15:0] fin, output bit acc);
        logic [15:0] s;
        bit ok;
        s = start;
        for (int k = 0; k < TRIES; k++) begin
            ok = int'(s[5:0]) <= NMAX;
`ifdef RNG_NO_REPEAT_EN
            ok = ok && (s[5:0] != last);
`endif
            if (ok) begin
                n = s[5:0]; d = k + 1; fin = lfsr_next(s); acc = 1;
                return;
            end
            s = lfsr_next(s);
        end
        n = (int'(last) == NMAX) ? 6'd0 : last + 6'd1;
        d = TRIES; fin = s; acc = 0;
    endfunction

    task automatic test_reset();
        nrst = 0; tick = 0; en = 0; seed_load = 0; note_ready = 0;
        step(); step();
        n_checks++; if (rand_out !== SEED) begin n_fail++; $display("FAIL reset_lfsr got %h want %h", rand_out, SEED); end
        n_checks++; if (note_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", note_valid); end
        n_checks++; if (note !== 6'd0) begin n_fail++; $display("FAIL reset_note got %0d want 0", note); end
        n_checks++; if (lockup !== 1'b0 || tick_drop !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b want 00", lockup, tick_drop); end
        nrst = 1;
        m_lfsr = SEED; m_last = 0;
    endtask

    task automatic test_seed(input logic [15:0] v);
        logic [15:0] exp_l;
        exp_l = (v == 16'hFFFF) ? SEED : v;
        seed_load = 1; seed = v;
        step();
        seed_load = 0;
        n_checks++; if (rand_out !== exp_l) begin n_fail++; $display("FAIL seed_lfsr got %h want %h", rand_out, exp_l); end
        n_checks++; if (lockup !== (v == 16'hFFFF)) begin n_fail++; $display("FAIL seed_lockup got %b want %b", lockup, v == 16'hFFFF); end
        step();
        n_checks++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL lockup_width got %b want 0", lockup); end
        m_lfsr = exp_l;
    endtask

    task automatic request(input int hold, input int drops, output logic [5:0] got);
        logic [5:0]  exp_n;
        logic [15:0] exp_l;
        int          d, k;
        bit          acc, t;
        draw_model(m_lfsr, m_last, exp_n, d, exp_l, acc);
        tick = 1;
        step();
        tick = 0;
        k = 0;
        while (note_valid !== 1'b1 && k < TRIES + 2) begin step(); k++; end
        n_checks++; if (k != d) begin n_fail++; $display("FAIL draw_latency got %0d want %0d", k, d); end
        n_checks++; if (note !== exp_n) begin n_fail++; $display("FAIL draw_note got %0d want %0d", note, exp_n); end
        n_checks++; if (rand_out !== exp_l) begin n_fail++; $display("FAIL draw_lfsr got %h want %h", rand_out, exp_l); end
        for (int i = 0; i < hold; i++) begin
            t = (i % 2 == 0) && (i / 2 < drops);
            tick = t;
            step();
            tick = 0;
            n_checks++; if (note_valid !== 1'b1 || note !== exp_n) begin n_fail++; $display("FAIL offer_hold got %b/%0d want 1/%0d", note_valid, note, exp_n); end
            n_checks++; if (tick_drop !== t) begin n_fail++; $display("FAIL tick_drop got %b want %b", tick_drop, t); end
        end
        note_ready = 1;
        step();
        note_ready = 0;
        n_checks++; if (note_valid !== 1'b0) begin n_fail++; $display("FAIL handshake got %b want 0", note_valid); end
        m_lfsr = exp_l;
        if (acc) m_last = exp_n;
        got = exp_n;
    endtask

    task automatic test_spec_vectors();
        logic [5:0] g;
        test_reset();
        request(0, 0, g);
        n_checks++; if (note !== 6'd21 || rand_out !== 16'h48AA) begin n_fail++; $display("FAIL first_note got %0d/%h want 21/48aa", note, rand_out); end
        request(0, 0, g);
        n_checks++; if (note !== 6'd42 || rand_out !== 16'h9155) begin n_fail++; $display("FAIL second_note got %0d/%h want 42/9155", note, rand_out); end
        test_reset();
        test_seed(16'h003F);
        request(0, 0, g);
        n_checks++; if (note !== 6'd1) begin n_fail++; $display("FAIL fallback got %0d want 1", note); end
        test_seed(16'hFFFF);
    endtask

    task automatic test_offer_hold();
        logic [5:0] g;
        request(5, 2, g);
        request(3, 2, g);
    endtask

    task automatic test_no_repeat();
        logic [5:0] g;
        test_reset();
        request(0, 0, g);
        test_seed(16'hA455);
        request(0, 0, g);
`ifdef RNG_NO_REPEAT_EN
        n_checks++; if (note !== 6'd42) begin n_fail++; $display("FAIL no_repeat got %0d want 42", note); end
`else
        n_checks++; if (note !== 6'd21) begin n_fail++; $display("FAIL repeat_ok got %0d want 21", note); end
`endif
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 1));
            step();
            if (en) m_lfsr = lfsr_next(m_lfsr);
            n_checks++; if (rand_out !== m_lfsr) begin n_fail++; $display("FAIL free_run got %h want %h", rand_out, m_lfsr); end
        end
        en = 0;
    endtask

    task automatic test_random();
        logic [5:0] g;
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 2) == 0) test_seed(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
            request($urandom_range(0, 4), $urandom_range(0, 2), g);
        end
    endtask

    task automatic test_reset_abort();
        test_reset();
        tick = 1;
        step();
        tick = 0;
        nrst = 0;
        step();
        nrst = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (note_valid !== 1'b0 || rand_out !== SEED) begin n_fail++; $display("FAIL reset_abort got %b/%h want 0/%h", note_valid, rand_out, SEED); end
        end
        m_lfsr = SEED; m_last = 0;
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_offer_hold();
        test_no_repeat();
        test_free_run();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
